gate_bist: RTL
==============

// Module: gate_bist
// PURPOSE
// - Synthesizable exhaustive tester for one 2-input combinational gate (simple_and and its siblings).
// - Drives the gate inputs through all four vectors in order 00, 01, 10, 11.
// - Samples the gate output for each vector and compares it with a parameterised truth table.
// - Reports a per-vector fail map, an error count and a pass flag through a start/busy/done handshake.
// - Sits beside the gate under test in an on-chip self-check wrapper. The gate needs no clock.
// PARAMETERS
// - TRUTH_TABLE    4'b1000  expected f, bit index = {a,b}. Default is AND.
// - SETTLE_CYCLES  2        cycles each vector is held before f_in is sampled. Legal range 1..15.
// PORTS
// - clk       in   1  single clock; everything updates on the rising edge
// - rst       in   1  synchronous, active-high reset
// - start     in   1  sampled only in IDLE or DONE; begins a run
// - a_out     out  1  registered drive to gate input a
// - b_out     out  1  registered drive to gate input b
// - f_in      in   1  gate output under test
// - busy      out  1  high while in DRIVE or SAMPLE
// - done      out  1  level; high in DONE until the next start or rst
// - pass      out  1  done && (fail_vec == 0)
// - fail_vec  out  4  bit i set if the vector {a,b}=i mismatched
// - err_count out  3  popcount(fail_vec), range 0..4
// BEHAVIOUR
// - Reset: state=IDLE; a_out=b_out=0; busy=done=pass=0; fail_vec=0; err_count=0; idx=0; settle counter=0.
// - FSM states: IDLE, DRIVE, SAMPLE, DONE. Encoding is 2-bit binary.
// - IDLE, start=1: go to DRIVE with idx=0, {a_out,b_out}=2'b00, settle counter=0, fail_vec cleared.
// - DRIVE: counter increments every cycle.
//   - When counter==SETTLE_CYCLES-1, go to SAMPLE.
//   - {a_out,b_out}={idx} is held stable throughout.
// - SAMPLE (exactly one cycle):
//   - fail_vec[idx] <= (f_in != TRUTH_TABLE[idx]).
//   - If idx==3, go to DONE.
//   - Otherwise idx++, drive the new vector, counter=0, return to DRIVE.
// - DONE: a_out=b_out=0, busy=0, done=1.
//   - start=1 restarts exactly as from IDLE; done and pass drop on that same edge.
// - Latency: the start-sampling edge is edge 0.
//   - Each vector occupies SETTLE_CYCLES+1 cycles.
//   - done rises at edge 4*(SETTLE_CYCLES+1). For the default, that is edge 12.
// - start while busy: ignored. No restart and no effect on the results.
// - In IDLE, a_out=b_out=0.
// - rst mid-run: back to the reset state on that edge. The partial fail_vec is discarded.
// - err_count and pass are derived registered copies of fail_vec, valid whenever done=1.
// - idx is 2 bits and never wraps inside a run. The transition to DONE ends the run.
// STRUCTURE
// - Shared defs include gate_bist_defs.vh holds:
//   - state encodings;
//   - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
// - One natural sub-module: gate_bist_settle_timer.
//   - Ports: clk, rst, load, expire.
//   - Counts SETTLE_CYCLES and pulses expire on the final count.
// - The FSM, vector register and result registers stay in gate_bist.
// TESTING
// 1. simple_and as the DUT, TT_AND, pulse start at edge 0 -> busy=1; done=1 at edge 12; fail_vec=0000, err_count=0, pass=1.
// 2. f_in tied 0, TT_AND -> fail_vec=4'b1000, err_count=1, pass=0.
//    f_in tied 1 -> fail_vec=4'b0111, err_count=3, pass=0.
// 3. Vector timing, default SETTLE_CYCLES -> {a_out,b_out} = 00 for 3 cycles, then 01, 10, 11 for 3 cycles each, then 00 in DONE.
// 4. start re-pulsed while busy (edge 5) -> sequence unchanged; done still at edge 12.
// 5. rst asserted at edge 7 mid-run -> next state IDLE; all outputs 0; a following start runs a clean full sequence.
// 6. From DONE with pass=0, restart with a correct DUT -> done and pass drop on the start edge; after 12 edges pass=1, fail_vec=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
// Shared definitions for the gate BIST block: the FSM state encoding, the
// reference truth tables of the supported 2-input gates (bit index = {a,b}),
// and a small popcount helper used for the error count.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/gate_bist_settle_timer.sv
// gate_bist_settle_timer
// Settle timer for one test vector. While load is high the count is held
// at zero; once load drops it counts up once per cycle and expire is high
// on the final count (SETTLE_CYCLES-1). The count parks there until the
// next load so expire cannot alias on a wrap.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   load   in  clear and hold the count at zero
//   expire out high on the final settle count
module gate_bist_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  assign expire = !load && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'd0;
    end else if (!expire) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_bist.sv
// gate_bist
// Exhaustive self-test of one 2-input combinational gate. On start the
// vectors {a,b} = 00, 01, 10, 11 are driven in turn, each held for
// SETTLE_CYCLES cycles and then sampled for one cycle against TRUTH_TABLE.
// Results are reported as a per-vector fail map, an error count and a
// pass flag.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | outputs quiet, waiting for start
//   ST_DRIVE  | current vector driven, settle timer running
//   ST_SAMPLE | one cycle: compare f_in, advance or finish
//   ST_DONE   | results held, done=1, start restarts
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   begin a run (honoured in IDLE/DONE only)
//   a_out     out  registered drive to gate input a
//   b_out     out  registered drive to gate input b
//   f_in      in   gate output under test
//   busy      out  run in progress
//   done      out  run finished, results valid
//   pass      out  done with no mismatches
//   fail_vec  out  bit i set if vector {a,b}=i mismatched
//   err_count out  number of mismatching vectors
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_AND,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] fail_q, fail_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       tmr_load, tmr_expire;

  gate_bist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    tmr_load = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        idx_d = 2'd0;
        if (start) begin
          state_d = ST_DRIVE;
          fail_d  = 4'b0000;
        end
      end
      ST_DRIVE: begin
        tmr_load = 1'b0;
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        fail_d[idx_q] = (f_in != TRUTH_TABLE[idx_q]);
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          idx_d   = 2'd0;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Summary registers track the fail map so they are valid as soon as done
    // rises, and pass drops on the same edge that leaves DONE.
    err_d  = popcount4(fail_d);
    pass_d = (state_d == ST_DONE) && (fail_d == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      fail_q  <= 4'b0000;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // idx_q is forced to zero outside a run, so it doubles as the vector drive.
  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule
